// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared lane count, latency bounds and read-pipeline stage record
package bram_pkg;

  localparam int BRAM_LANES = 4;
  localparam int BRAM_DW    = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  typedef enum logic {
    SRC_ACC  = 1'b0,
    SRC_HOST = 1'b1
  } src_e;

  typedef struct packed {
    logic               valid;
    src_e               src;
    logic               oob;
    logic [BRAM_DW-1:0] data;
  } stage_t;

  // Flat layout of stage_t, data in the low bits.
  localparam int STG_DATA_LSB  = 0;
  localparam int STG_OOB_BIT   = BRAM_DW;
  localparam int STG_SRC_BIT   = BRAM_DW + 1;
  localparam int STG_VALID_BIT = BRAM_DW + 2;
  localparam int STG_WIDTH     = BRAM_DW + 3;

  function automatic logic [BRAM_DW-1:0] lane_merge(
    input logic [BRAM_DW-1:0]    old_word,
    input logic [BRAM_DW-1:0]    new_word,
    input logic [BRAM_LANES-1:0] be
  );
    lane_merge = old_word;
    for (int i = 0; i < BRAM_LANES; i++) begin
      if (be[i]) lane_merge[8*i +: 8] = new_word[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// rtl/bram_rd_pipe.sv - read-latency shift register of stage records with async clear
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t in_stage,
  output stage_t out_stage
);

  if ($bits(stage_t) != STG_WIDTH || STG_VALID_BIT != STG_WIDTH - 1 ||
      STG_SRC_BIT != STG_OOB_BIT + 1 || STG_DATA_LSB != 0) begin : g_bad_stage
    $error("bram_rd_pipe: stage_t layout does not match its field offsets");
  end

  stage_t stg_q [DEPTH];
  stage_t stg_d [DEPTH];

  always_comb begin
    stg_d[0] = in_stage;
    for (int i = 1; i < DEPTH; i++) stg_d[i] = stg_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign out_stage = stg_q[DEPTH-1];

endmodule

// File: rtl/bram_responder.sv
// rtl/bram_responder.sv - word RAM answering an accelerator BRAM port and a host valid/ready port
module bram_responder
  import bram_pkg::*;
#(
  parameter int RAM_SIZE   = 1024,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LSB   = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           addr_bram,
  input  logic                  enable_bram,
  input  logic [BRAM_LANES-1:0] w_enable_bram,
  input  logic [DATA_WIDTH-1:0] data_in_bram,
  output logic [DATA_WIDTH-1:0] data_out_bram,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_rsp_valid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  err_oob,
  input  logic                  err_clr
);

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("bram_responder: RD_LATENCY must be within 1..3");
  end
  if (DATA_WIDTH != BRAM_DW) begin : g_bad_width
    $error("bram_responder: DATA_WIDTH must be 32");
  end

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  // Assert immediately, release two clocks after reset rises.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end
  assign rst_n_int = rst_sync_q[1];

  logic [DATA_WIDTH-1:0] mem_q [RAM_SIZE];
  logic [31:0]           acc_word;
  logic                  acc_oob, host_oob, host_go;
  logic                  mem_we, err_set;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata, rd_word;
  logic [DATA_WIDTH-1:0] acc_hold_q, acc_hold_d, host_hold_q, host_hold_d;
  logic                  err_oob_q, err_oob_d;
  stage_t                issue, retire;

  assign acc_word       = addr_bram >> ADDR_LSB;
  assign acc_oob        = acc_word >= 32'(RAM_SIZE);
  assign host_oob       = 32'(host_addr) >= 32'(RAM_SIZE);
  assign host_req_ready = ~enable_bram;
  assign host_go        = host_req_valid & ~enable_bram;

  // Accelerator owns the array whenever it strobes; every accelerator access reads the pre-write word.
  always_comb begin
    issue     = '0;
    mem_we    = 1'b0;
    mem_idx   = acc_word[ADDR_WIDTH-1:0];
    mem_wdata = '0;
    err_set   = 1'b0;
    if (enable_bram) begin
      issue.valid = 1'b1;
      issue.src   = SRC_ACC;
      issue.oob   = acc_oob;
      issue.data  = mem_q[mem_idx];
      err_set     = acc_oob;
      mem_we      = (|w_enable_bram) && !acc_oob;
      mem_wdata   = lane_merge(mem_q[mem_idx], data_in_bram, w_enable_bram);
    end else if (host_go) begin
      mem_idx = host_addr;
      err_set = host_oob;
      if (host_we) begin
        mem_we    = !host_oob;
        mem_wdata = host_wdata;
      end else begin
        issue.valid = 1'b1;
        issue.src   = SRC_HOST;
        issue.oob   = host_oob;
        issue.data  = mem_q[host_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end

  bram_rd_pipe #(.DEPTH(RD_LATENCY)) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n_int),
    .in_stage  (issue),
    .out_stage (retire)
  );

  always_comb begin
    rd_word     = retire.oob ? '0 : retire.data;
    acc_hold_d  = acc_hold_q;
    host_hold_d = host_hold_q;
    if (retire.valid && retire.src == SRC_ACC)  acc_hold_d  = rd_word;
    if (retire.valid && retire.src == SRC_HOST) host_hold_d = rd_word;
    err_oob_d = err_set | (err_oob_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      acc_hold_q  <= '0;
      host_hold_q <= '0;
      err_oob_q   <= 1'b0;
    end else begin
      acc_hold_q  <= acc_hold_d;
      host_hold_q <= host_hold_d;
      err_oob_q   <= err_oob_d;
    end
  end

  assign data_out_bram  = acc_hold_d;
  assign host_rdata     = host_hold_d;
  assign host_rsp_valid = retire.valid && (retire.src == SRC_HOST);
  assign err_oob        = err_oob_q;

endmodule
